// File: rtl/tone_segment_scheduler_pkg.sv
// Shared types and default widths for the tone segment scheduler.
package tone_sched_pkg;

  localparam int DEF_HOP_WIDTH  = 6;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_ADDR_WIDTH = $clog2(DEF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [DEF_HOP_WIDTH-1:0] hop;
    logic [DEF_LEN_WIDTH-1:0] len;
  } segment_t;

endpackage

// File: rtl/tone_segment_scheduler_if.sv
// Host-side control/table bus plus generator-side outputs of the scheduler.
interface tone_segment_scheduler_if
  import tone_sched_pkg::*;
#(
  parameter int HOP_WIDTH  = DEF_HOP_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [HOP_WIDTH-1:0]  wr_hop;
  logic [LEN_WIDTH-1:0]  wr_len;
  logic [ADDR_WIDTH:0]   num_segments;
  logic                  loop_en;
  logic                  start;
  logic                  abort;

  logic [HOP_WIDTH-1:0]  hop_amount;
  logic                  gen_rst_active_low;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] seg_index;

  // Host / register side
  modport master (
    output wr_en, wr_addr, wr_hop, wr_len, num_segments, loop_en, start, abort,
    input  hop_amount, gen_rst_active_low, busy, done, seg_index
  );

  // Scheduler side
  modport slave (
    input  wr_en, wr_addr, wr_hop, wr_len, num_segments, loop_en, start, abort,
    output hop_amount, gen_rst_active_low, busy, done, seg_index
  );

endinterface

// File: rtl/tone_segment_scheduler_segment_table.sv
// Segment RAM: one write port, one registered read port, no reset on contents.
module segment_table
  import tone_sched_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_HOP_WIDTH + DEF_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry and register the read data every cycle
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/tone_segment_scheduler.sv
// Steps the sine/cosine generator through a table of (hop, length) segments,
// holding the generator in reset while idle so each sequence starts at phase 0.
module tone_segment_scheduler
  import tone_sched_pkg::*;
#(
  parameter int HOP_WIDTH  = DEF_HOP_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic gen_clk,
  input logic rst_active_high,
  tone_segment_scheduler_if.slave bus
);

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   IDX_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_q;
  logic [HOP_WIDTH-1:0]    hopAmount_q;
  logic                    genRstN_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   segIndex_q;
  logic [LEN_WIDTH-1:0]    lenCount_q;
  logic [ADDR_WIDTH:0]     numSeg_q;
  logic                    loopEn_q;

  logic [ADDR_WIDTH:0]     numClamped;
  logic [ADDR_WIDTH-1:0]   segIndex_d;
  logic [ADDR_WIDTH-1:0]   rdAddr;
  logic [HOP_WIDTH+LEN_WIDTH-1:0] rdData;
  logic [HOP_WIDTH-1:0]    rdHop;
  logic [LEN_WIDTH-1:0]    rdLen;
  logic [LEN_WIDTH-1:0]    rdLenEff;
  logic                    segEnd;
  logic                    lastSeg;
  logic                    tableWe;

  // Index that follows idx in the programmed list, wrapping to 0 after the last
  function automatic logic [ADDR_WIDTH-1:0] nextIndex(input logic [ADDR_WIDTH-1:0] idx,
                                                      input logic [ADDR_WIDTH:0]   count);
    logic [ADDR_WIDTH:0] inc;
    inc = {1'b0, idx} + IDX_ONE;
    return (inc >= count) ? '0 : inc[ADDR_WIDTH-1:0];
  endfunction

  assign tableWe = bus.wr_en && !busy_q;

  segment_table #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (HOP_WIDTH + LEN_WIDTH)
  ) u_table (
    .clk_i   (gen_clk),
    .we_i    (tableWe),
    .waddr_i (bus.wr_addr),
    .wdata_i ({bus.wr_hop, bus.wr_len}),
    .raddr_i (rdAddr),
    .rdata_o (rdData)
  );

  // The read address always runs one segment ahead of the index being played:
  // in IDLE it points at entry 0 so ALIGN sees it, in ALIGN/RUN it points at the
  // successor of whatever index will be current after this edge. That way the
  // next segment is already sitting in rdData on the final cycle of the current
  // one, even for one-cycle segments.
  always_comb begin
    numClamped = (bus.num_segments > DEPTH_W) ? DEPTH_W : bus.num_segments;
    rdHop      = rdData[HOP_WIDTH+LEN_WIDTH-1:LEN_WIDTH];
    rdLen      = rdData[LEN_WIDTH-1:0];
    rdLenEff   = (rdLen == '0) ? LEN_ONE : rdLen;
    segEnd     = (state_q == RUN) && (lenCount_q == LEN_ONE);
    lastSeg    = (({1'b0, segIndex_q} + IDX_ONE) >= numSeg_q);
    segIndex_d = '0;
    if (state_q == RUN) begin
      segIndex_d = segEnd ? nextIndex(segIndex_q, numSeg_q) : segIndex_q;
    end
    rdAddr = (state_q == IDLE) ? '0 : nextIndex(segIndex_d, numSeg_q);
  end

  // Sequencer FSM with all outputs registered; abort beats every other input
  always_ff @(posedge gen_clk or posedge rst_active_high) begin
    if (rst_active_high) begin
      state_q     <= IDLE;
      hopAmount_q <= '0;
      genRstN_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      segIndex_q  <= '0;
      lenCount_q  <= LEN_ONE;
      numSeg_q    <= '0;
      loopEn_q    <= 1'b0;
    end else if (bus.abort) begin
      state_q     <= IDLE;
      hopAmount_q <= '0;
      genRstN_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      segIndex_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && (numClamped != '0)) begin
            state_q  <= ALIGN;
            busy_q   <= 1'b1;
            numSeg_q <= numClamped;
            loopEn_q <= bus.loop_en;
          end
        end
        ALIGN: begin
          state_q     <= RUN;
          hopAmount_q <= rdHop;
          lenCount_q  <= rdLenEff;
          segIndex_q  <= '0;
          genRstN_q   <= 1'b1;
        end
        RUN: begin
          if (segEnd) begin
            if (lastSeg && !loopEn_q) begin
              state_q     <= DONE;
              hopAmount_q <= '0;
              genRstN_q   <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              segIndex_q  <= '0;
            end else begin
              hopAmount_q <= rdHop;
              lenCount_q  <= rdLenEff;
              segIndex_q  <= segIndex_d;
            end
          end else begin
            lenCount_q <= lenCount_q - LEN_ONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.hop_amount         = hopAmount_q;
  assign bus.gen_rst_active_low = genRstN_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.seg_index          = segIndex_q;

endmodule

// File: tb/tb_tone_segment_scheduler.sv
// Scoreboard bench for tone_segment_scheduler: the driver expands each accepted
// start into the full per-cycle output trace from the segment list, and an
// independent monitor pops and compares one expected tuple per clock.
module tb_tone_segment_scheduler;
  import tone_sched_pkg::*;

  localparam int HW          = DEF_HOP_WIDTH;
  localparam int LW          = DEF_LEN_WIDTH;
  localparam int AW          = DEF_ADDR_WIDTH;
  localparam int DEPTH       = DEF_DEPTH;
  localparam int LOOP_PREFIX = 40;

  typedef struct packed {
    logic [HW-1:0] hop;
    logic          grn;
    logic          busy;
    logic          done;
    logic [AW-1:0] idx;
    logic          chkIdx;
  } exp_t;

  logic gen_clk;
  logic rst;

  tone_segment_scheduler_if bus ();

  tone_segment_scheduler dut (
    .gen_clk         (gen_clk),
    .rst_active_high (rst),
    .bus             (bus)
  );

  initial gen_clk = 1'b0;
  always #5 gen_clk = ~gen_clk;

  segment_t modelTab [DEPTH];
  exp_t     expQ [$];
  int       ahead    = 0;
  bit       lastBusy = 1'b0;
  bit       lastIdle = 1'b1;
  int       checks   = 0;
  int       errors   = 0;
  string    phase    = "reset";

  // Build one expected output tuple
  function automatic exp_t mkExp(input int hop, input bit grn, input bit busy,
                                 input bit done, input int idx, input bit chk);
    exp_t e;
    e.hop    = hop[HW-1:0];
    e.grn    = grn;
    e.busy   = busy;
    e.done   = done;
    e.idx    = idx[AW-1:0];
    e.chkIdx = chk;
    return e;
  endfunction

  // A programmed length of zero still plays for one cycle
  function automatic int effLen(input logic [LW-1:0] l);
    return (l == '0) ? 1 : int'(l);
  endfunction

  // Compare the DUT outputs against one expected tuple
  task automatic checkOutput(input exp_t e, input string name);
    checks++;
    if (bus.hop_amount !== e.hop || bus.gen_rst_active_low !== e.grn ||
        bus.busy !== e.busy || bus.done !== e.done ||
        (e.chkIdx && bus.seg_index !== e.idx)) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got hop=%0d rstn=%0b busy=%0b done=%0b idx=%0d, want hop=%0d rstn=%0b busy=%0b done=%0b idx=%0d",
               name, $time, bus.hop_amount, bus.gen_rst_active_low, bus.busy, bus.done,
               bus.seg_index, e.hop, e.grn, e.busy, e.done, e.idx);
    end
  endtask

  // Monitor: one expected tuple per cycle, sampled 1ns after the rising edge
  initial begin
    forever begin
      exp_t e;
      @(posedge gen_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e, phase);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue what must follow
  task automatic applyStimulus(input bit st, input bit ab, input bit we, input int addr,
                               input int hop, input int len, input int nseg, input bit lp);
    @(negedge gen_clk);
    bus.start        = st;
    bus.abort        = ab;
    bus.wr_en        = we;
    bus.wr_addr      = addr[AW-1:0];
    bus.wr_hop       = hop[HW-1:0];
    bus.wr_len       = len[LW-1:0];
    bus.num_segments = nseg[AW:0];
    bus.loop_en      = lp;
    if (we && !lastBusy) begin
      modelTab[addr[AW-1:0]].hop = hop[HW-1:0];
      modelTab[addr[AW-1:0]].len = len[LW-1:0];
    end
    if (ab) begin
      repeat (ahead) void'(expQ.pop_back());
      ahead = 0;
      expQ.push_back(mkExp(0, 0, 0, 0, 0, 1));
    end else if (ahead > 0) begin
      ahead--;
    end else if (st && lastIdle && nseg != 0) begin
      int n;
      int cnt;
      int k;
      n   = (nseg > DEPTH) ? DEPTH : nseg;
      cnt = 1;
      k   = 0;
      expQ.push_back(mkExp(0, 0, 1, 0, 0, 0));
      do begin
        int l;
        l = effLen(modelTab[k].len);
        for (int c = 0; c < l; c++) expQ.push_back(mkExp(int'(modelTab[k].hop), 1, 1, 0, k, 1));
        cnt += l;
        k = (k + 1 == n) ? 0 : k + 1;
      end while (lp ? (cnt < LOOP_PREFIX) : (k != 0));
      if (!lp) expQ.push_back(mkExp(0, 0, 0, 1, 0, 0));
      ahead = expQ.size() - 1;
    end else begin
      expQ.push_back(mkExp(0, 0, 0, 0, 0, 1));
    end
    lastBusy = expQ[0].busy;
    lastIdle = !expQ[0].busy && !expQ[0].done;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeEntry(input int a, input int h, input int l);
    applyStimulus(0, 0, 1, a, h, l, 0, 0);
  endtask

  task automatic startRun(input int nseg, input bit lp);
    applyStimulus(1, 0, 0, 0, 0, 0, nseg, lp);
  endtask

  // Outputs must sit at their reset values right now, without a clock edge
  task automatic checkResetOutputs(input string name);
    checks++;
    if (bus.hop_amount !== '0 || bus.gen_rst_active_low !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.seg_index !== '0) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got hop=%0d rstn=%0b busy=%0b done=%0b idx=%0d, want all zero",
               name, $time, bus.hop_amount, bus.gen_rst_active_low, bus.busy, bus.done,
               bus.seg_index);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_hop       = '0;
    bus.wr_len       = '0;
    bus.num_segments = '0;
    bus.loop_en      = 1'b0;

    repeat (2) @(posedge gen_clk);
    #2;
    checkResetOutputs("reset_state");
    @(negedge gen_clk);
    rst = 1'b0;
    idle(2);

    phase = "fill_table";
    for (int a = 0; a < DEPTH; a++) writeEntry(a, $urandom_range(1, 63), $urandom_range(0, 4));
    writeEntry(0, 1, 4);
    writeEntry(1, 3, 2);
    idle(2);

    phase = "basic_run";
    startRun(2, 0);
    idle(10);

    phase = "busy_write_and_start";
    startRun(2, 0);
    writeEntry(0, 7, 9);
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 1);
    writeEntry(1, 9, 1);
    idle(8);
    startRun(2, 0);
    idle(10);

    phase = "loop";
    startRun(2, 1);
    idle(20);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);

    phase = "abort_mid_run";
    startRun(2, 0);
    idle(3);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(3);
    phase = "restart_after_abort";
    startRun(2, 0);
    idle(10);

    phase = "zero_segments";
    startRun(0, 0);
    idle(4);
    phase = "abort_beats_start";
    applyStimulus(1, 1, 0, 0, 0, 0, 2, 0);
    idle(4);

    phase = "zero_length";
    writeEntry(0, 5, 0);
    writeEntry(1, 9, 2);
    writeEntry(2, 12, 0);
    startRun(3, 0);
    idle(8);
    startRun(1, 1);
    idle(6);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    phase = "clamped_count";
    startRun(31, 0);
    total = 0;
    for (int a = 0; a < DEPTH; a++) total += effLen(modelTab[a].len);
    idle(total + 5);

    for (int it = 0; it < 6; it++) begin
      int ns;
      phase = "random";
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 1) == 1) writeEntry(a, $urandom_range(0, 63), $urandom_range(0, 5));
      end
      ns = (it == 5) ? $urandom_range(17, 31) : $urandom_range(1, 16);
      startRun(ns, 0);
      total = 0;
      for (int a = 0; a < ((ns > DEPTH) ? DEPTH : ns); a++) total += effLen(modelTab[a].len);
      idle(total + 4);
    end

    phase = "reset_mid_run";
    writeEntry(0, 1, 4);
    writeEntry(1, 3, 2);
    startRun(2, 0);
    idle(3);
    @(posedge gen_clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetOutputs("reset_mid_run_async");
    expQ.delete();
    ahead    = 0;
    lastBusy = 1'b0;
    lastIdle = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    phase = "run_after_reset";
    startRun(2, 0);
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_segment_scheduler.md
# tone_segment_scheduler

Sequences the sine/cosine generator through a programmed list of frequency segments. Each segment is a (hop, length) pair: it drives the generator's `hop_amount` for exactly `length` gen_clk cycles, then advances. The block also owns the generator's `rst_active_low`, holding phase at 0 while idle so every sequence starts phase-aligned. It sits between the host register interface and the generator.

## Interface
- `HOP_WIDTH`, 6, width of the hop value; matches generator `hop_amount`.
- `LEN_WIDTH`, 16, width of a segment length, in cycles.
- `DEPTH`, 16, number of segment table entries.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, segment index width.
- `gen_clk` in 1: sole clock.
- `rst_active_high` in 1: asynchronous, active-high reset.
- `wr_en` in 1: table write strobe.
- `wr_addr` in ADDR_WIDTH: table write address.
- `wr_hop` in HOP_WIDTH: hop value to write.
- `wr_len` in LEN_WIDTH: length value to write.
- `num_segments` in ADDR_WIDTH+1: count of segments to play; sampled on start.
- `loop_en` in 1: wrap from the last segment to segment 0 instead of finishing; sampled on start.
- `start` in 1: single-cycle start pulse.
- `abort` in 1: stop immediately.
- `hop_amount` out HOP_WIDTH: to generator `hop_amount`.
- `gen_rst_active_low` out 1: to generator `rst_active_low`.
- `busy` out 1: high in ALIGN and RUN.
- `done` out 1: one-cycle pulse when a non-looping sequence completes.
- `seg_index` out ADDR_WIDTH: index of the segment currently driven.

## Operation
- **Table:** DEPTH entries of {hop, len}, with synchronous read.
  - A write takes effect when `wr_en` is high and `busy` is low.
  - Writes while busy are dropped.
- **Length:** a `len` of 0 is treated as 1.
- **`num_segments`:** 0 means `start` is ignored. Values above DEPTH are clamped to DEPTH.
- **IDLE**
  - Outputs: `hop_amount`=0, `gen_rst_active_low`=0, `busy`=0.
  - `start` with `num_segments`≠0 → ALIGN.
- **ALIGN** (exactly 1 cycle)
  - Fetches entry 0.
  - `gen_rst_active_low` stays 0.
  - Next state: RUN.
- **RUN**
  - Outputs: `gen_rst_active_low`=1, `hop_amount`=hop[seg_index].
  - A down-counter is loaded with max(len,1). Next entry is prefetched so `hop_amount` changes exactly on the segment boundary, with no bubble.
  - At the end of the last segment:
    - `loop_en`=1 → segment 0. No realign; phase is continuous.
    - `loop_en`=0 → DONE.
- **DONE** (1 cycle)
  - Outputs: `done`=1, `hop_amount`=0, `gen_rst_active_low`=0.
  - Next state: IDLE.
- **Abort:** `abort` in any state → IDLE on the next edge. No `done` pulse; `abort` has priority over `start`.
- **Start while busy:** ignored.
- **Reset mid-operation:** immediate IDLE; all outputs at their reset values.
- **Reset values:** `hop_amount`=0, `gen_rst_active_low`=0, `busy`=0, `done`=0, `seg_index`=0. State=IDLE; table contents undefined.

## Timing
- All outputs are registered.
- `start` sampled at edge T:
  - ALIGN during cycle T+1 (`busy`=1).
  - First RUN cycle T+2, with `hop_amount`=hop0 and `gen_rst_active_low`=1.
- Segment k occupies max(len_k,1) consecutive cycles. `seg_index` updates in the same cycle as `hop_amount`.
- Non-looping total `busy` time = 1 + Σ max(len_k,1). `done` is asserted in the first cycle after the last RUN cycle, with `busy`=0.
- Generator output follows `hop_amount` with the generator's own 1-cycle phase register and 1-cycle table register; the scheduler does not compensate.

## Structure
- **Shared package `tone_sched_pkg`:**
  - State enum: IDLE, ALIGN, RUN, DONE.
  - `segment_t` struct {hop, len}.
  - Default width constants.
- **Sub-module `segment_table`:** DEPTH×(HOP_WIDTH+LEN_WIDTH) RAM, one write port, one synchronous read port.
- The FSM, length counter and index counter live in the top module.

## Test plan
- Program {hop=1,len=4},{hop=3,len=2}; `num_segments`=2, `loop_en`=0; start at T:
  - ALIGN at T+1.
  - `hop_amount`=1 for T+2..T+5, then 3 for T+6..T+7.
  - `done` at T+8; `busy` low from T+8.
- `len`=0 entry → `hop_amount` held for exactly 1 cycle.
- Same program with `loop_en`=1, run 20 cycles → pattern 1,1,1,1,3,3 repeats; `gen_rst_active_low` never drops; no `done`.
- `abort` at cycle T+4 of the first scenario → T+5: IDLE, `hop_amount`=0, `gen_rst_active_low`=0, no `done`. A restart reproduces the first scenario exactly.
- Illegal starts and writes:
  - `start` with `num_segments`=0 → `busy` stays 0.
  - `start` while busy → no effect.
  - `wr_en` while busy → entry unchanged on the next run.
- Assert `rst_active_high` mid-RUN → all outputs at reset values immediately, without waiting for a clock edge.
